// File: rtl/mips_instr_encoder.sv
// Packs mnemonic-level requests into 32-bit MIPS words and streams them, with program addresses, from a small FIFO.
// Optional ENC_NOP_PAD_EN: branch/jump kinds also push a delay-slot NOP in the same cycle.
module mips_instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_kind,
  input  logic [4:0]               in_rs,
  input  logic [4:0]               in_rt,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_shamt,
  input  logic [15:0]              in_imm,
  input  logic [25:0]              in_target,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] FMT_R = 2'd0, FMT_I = 2'd1, FMT_J = 2'd2;

  logic [31:0] r_mem [DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic [31:0] r_addr;
  logic        r_err;

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [1:0]  w_fmt;
  logic        w_legal;
  logic [31:0] w_instr;
  logic        w_full, w_empty, w_accept, w_push, w_pop;
  logic [AW:0] w_count, w_push_cnt;
  logic [AW-1:0] w_wr_idx;

  always_comb begin
    w_op    = 6'h00;
    w_funct = 6'h00;
    w_rs    = in_rs;
    w_rt    = in_rt;
    w_rd    = in_rd;
    w_shamt = 5'd0;
    w_fmt   = FMT_R;
    w_legal = 1'b1;
    case (in_kind)
      5'd0:  w_funct = 6'h20;
      5'd1:  w_funct = 6'h22;
      5'd2:  w_funct = 6'h24;
      5'd3:  w_funct = 6'h25;
      5'd4:  w_funct = 6'h2A;
      5'd5:  w_funct = 6'h2B;
      5'd6:  w_funct = 6'h21;
      5'd7:  w_funct = 6'h23;
      5'd8:  w_funct = 6'h27;
      5'd9:  begin w_funct = 6'h08; w_rt = 5'd0; w_rd = 5'd0; end
      5'd10: begin w_funct = 6'h09; w_rt = 5'd0; end
      5'd11: begin w_funct = 6'h00; w_rs = 5'd0; w_shamt = in_shamt; end
      5'd12: begin w_funct = 6'h02; w_rs = 5'd0; w_shamt = in_shamt; end
      5'd13: begin w_op = 6'h08; w_fmt = FMT_I; end
      5'd14: begin w_op = 6'h0D; w_fmt = FMT_I; end
      5'd15: begin w_op = 6'h23; w_fmt = FMT_I; end
      5'd16: begin w_op = 6'h2B; w_fmt = FMT_I; end
      5'd17: begin w_op = 6'h04; w_fmt = FMT_I; end
      5'd18: begin w_op = 6'h05; w_fmt = FMT_I; end
      5'd19: begin w_op = 6'h0C; w_fmt = FMT_I; end
      5'd20: begin w_op = 6'h0A; w_fmt = FMT_I; end
      5'd21: begin w_op = 6'h0F; w_fmt = FMT_I; w_rs = 5'd0; end
      5'd22: begin w_op = 6'h02; w_fmt = FMT_J; end
      5'd23: begin w_op = 6'h03; w_fmt = FMT_J; end
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (w_fmt)
      FMT_I:   w_instr = {w_op, w_rs, w_rt, in_imm};
      FMT_J:   w_instr = {w_op, in_target};
      default: w_instr = {w_op, w_rs, w_rt, w_rd, w_shamt, w_funct};
    endcase
  end

  // Full when the wrap bits differ but the index bits match.
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_wr_idx = r_wr_ptr[AW-1:0];

`ifdef ENC_NOP_PAD_EN
  logic          w_ctrl;
  logic [AW-1:0] w_wr_idx1;
  assign w_ctrl     = (in_kind == 5'd9)  || (in_kind == 5'd10) || (in_kind == 5'd17) ||
                      (in_kind == 5'd18) || (in_kind == 5'd22) || (in_kind == 5'd23);
  assign w_wr_idx1  = w_wr_idx + {{(AW-1){1'b0}}, 1'b1};
  assign in_ready   = (w_count <= (AW+1)'(DEPTH - 2));
  assign w_push_cnt = w_push ? (w_ctrl ? (AW+1)'(2) : (AW+1)'(1)) : '0;
`else
  assign in_ready   = !w_full;
  assign w_push_cnt = w_push ? (AW+1)'(1) : '0;
`endif

  assign w_accept  = in_valid && in_ready;
  assign w_push    = w_accept && w_legal;
  assign w_pop     = !w_empty && out_ready;
  assign out_valid = !w_empty;
  assign out_instr = r_mem[r_rd_ptr[AW-1:0]];
  assign out_addr  = r_addr;
  assign count     = w_count;
  assign err       = r_err;

  // Storage carries no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_idx] <= w_instr;
`ifdef ENC_NOP_PAD_EN
      if (w_ctrl) r_mem[w_wr_idx1] <= 32'h0000_0000;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_addr   <= BASE_ADDR;
      r_err    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_push_cnt;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        r_addr   <= r_addr + 32'd4;
      end
      if (w_accept && !w_legal) r_err <= 1'b1;
    end
  end
endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Sequential MIPS instruction encoder: the write-side counterpart of the control decoder. Accepts mnemonic-level requests (kind + register/immediate fields) over a valid/ready handshake, packs them into 32-bit instruction words, buffers them in a small FIFO and streams them with their program addresses to the instruction-memory loader. It builds test programs for the single-cycle CPU from testbench or scripted sources, in exactly the opcode/funct set the control decoder recognises.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥ 2
- BASE_ADDR, 32'h0000_3000: address of the first emitted word
- clk  in  1  rising-edge clock
- rstn  in  1  synchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_kind  in  5  mnemonic enum (see Operation)
- in_rs / in_rt / in_rd / in_shamt  in  5 each  register and shift fields
- in_imm  in  16  immediate / branch offset
- in_target  in  26  jump target field
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes word when out_valid & out_ready
- out_instr  out  32  encoded instruction at FIFO head
- out_addr  out  32  program address of out_instr
- count  out  $clog2(DEPTH)+1  current FIFO occupancy
- err  out  1  sticky: illegal in_kind seen

## Operation
- Kind enum → encoding (op/funct hex):
  - R-type, op 00: 0 add 20, 1 sub 22, 2 and 24, 3 or 25, 4 slt 2A, 5 sltu 2B, 6 addu 21, 7 subu 23, 8 nor 27, 9 jr 08, 10 jalr 09, 11 sll 00, 12 srl 02.
  - I-type: 13 addi 08, 14 ori 0D, 15 lw 23, 16 sw 2B, 17 beq 04, 18 bne 05, 19 andi 0C, 20 slti 0A, 21 lui 0F.
  - J-type: 22 j 02, 23 jal 03.
- R: {op, rs, rt, rd, shamt, funct}. shamt forced 0 except sll/srl.
- Forced-zero fields: sll/srl rs=0; jr rt=rd=0; jalr rt=0; lui rs=0.
- I: {op, rs, rt, imm}. J: {op, target}.
- Kinds 24–31 are illegal: handshake completes, nothing queued, err set until reset.
- FIFO: circular buffer; read/write pointers one bit wider than log2(DEPTH); full when MSBs differ and the rest are equal.
- in_ready = !full. No bypass when full, even if a pop occurs in the same cycle.
- Push and pop in the same cycle (not full, not empty): count unchanged, both pointers advance.
- out_addr is a counter: reset to BASE_ADDR, +4 on each out handshake, wraps modulo 2^32.

## Timing
- Reset (rstn=0 at a clk edge): pointers=0, count=0, out_valid=0, err=0, out_addr=BASE_ADDR. out_instr is don't-care while out_valid=0.
- Reset mid-stream discards all queued words.
- Latency: a request accepted at edge N gives out_valid=1 after edge N when the FIFO was empty. No combinational path from in_* to out_*.
- out_instr and out_addr hold stable while out_valid & !out_ready.
- in_ready and out_valid are functions of registered state only.
- err is set on the edge where the illegal request is accepted.

## Configuration
- ENC_NOP_PAD_EN defined: each branch/jump kind (9, 10, 17, 18, 22, 23) pushes two words, the instruction then 32'h0000_0000 (delay-slot NOP), in one cycle.
  - in_ready = (free entries ≥ 2) for every kind.
  - count rises by 2.
  - The NOP takes the next address.
- Undefined: one word per request; in_ready = !full.

## Test plan
- add rd=3 rs=1 rt=2, out_ready=1 → out_instr 0x00221820, out_addr 0x00003000, out_valid exactly one cycle after acceptance.
- addi rt=8 rs=0 imm=FFFF, then beq rs=1 rt=2 imm=FFFD → 0x2008FFFF @0x3000, 0x1022FFFD @0x3004. With ENC_NOP_PAD_EN: a third word 0x00000000 @0x3008.
- sll rd=2 rt=1 shamt=4 with in_rs=7 → 0x00011100 (rs ignored). jal target=0x100 → 0x0C000100.
- out_ready=0, four requests with DEPTH=4 → count=4, in_ready=0. A fifth request stalls. Raise out_ready → words drain in order at 0x3000..0x300C, and the stalled request is accepted the cycle after in_ready rises.
- in_kind=25 → handshake completes, count stays 0, err=1 and holds through later legal traffic until rstn=0.
- rstn=0 with three words queued → next cycle count=0, out_valid=0, err=0. The next emitted word is at 0x3000.
